// File: rtl/elevator_dispatcher.sv
// SCAN-ordered collective-control scheduler for a small elevator.
// Latches floor calls, steps the car on 1 s ticks and sequences the door
// dwell. Optional door_hold input when ELEV_DOOR_HOLD_EN is defined.
// Ports: CLOCK_50, rst_n (async, active-low), tick, req_valid, req_floor,
//   [door_hold], req_ack, req_err, pending, cur_floor, state, direction,
//   door_open, arrive.
module elevator_dispatcher #(
  parameter int NUM_FLOORS   = 10,
  parameter int DOOR_TICKS   = 5,
  parameter int TRAVEL_TICKS = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  req_valid,
  input  logic [3:0]            req_floor,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic                  req_ack,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] cur_floor,
  output logic [1:0]            state,
  output logic                  direction,
  output logic                  door_open,
  output logic                  arrive
);

  localparam int NF = NUM_FLOORS;
  localparam logic [NF-1:0] ONE = NF'(1);
  localparam logic [3:0] DOOR_LAST = 4'(DOOR_TICKS - 1);
  localparam logic [3:0] TRAV_LAST = 4'(TRAVEL_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_BUSY = 2'b10,
    S_TRAV = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [NF-1:0] cur_q, cur_d;
  logic [NF-1:0] pend_q, pend_d;
  logic [3:0]    trav_q, trav_d;
  logic [3:0]    door_q, door_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          arr_q, arr_d;

  logic          hold;
  logic          req_ok;
  logic [NF-1:0] set_mask;
  logic          clr;
  logic [NF-1:0] pend_eval;
  logic [NF-1:0] below_mask;
  logic [NF-1:0] above_mask;
  logic          here, any_up, any_dn, ahead, behind;
  logic          at_end;
  logic [NF-1:0] nxt;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign req_ok = req_valid && (req_floor != 4'd0)
               && ({28'd0, req_floor} <= NF);
  assign set_mask = req_ok ? (ONE << (req_floor - 4'd1)) : '0;

  // At door close the decision must see pending with this floor cleared.
  assign pend_eval = (state_q == S_BUSY) ? (pend_q & ~cur_q) : pend_q;
  assign below_mask = cur_q - ONE;
  assign above_mask = ~(below_mask | cur_q);
  assign here   = |(pend_eval & cur_q);
  assign any_up = |(pend_eval & above_mask);
  assign any_dn = |(pend_eval & below_mask);
  assign ahead  = dir_q ? any_up : any_dn;
  assign behind = dir_q ? any_dn : any_up;
  assign at_end = dir_q ? cur_q[NF-1] : cur_q[0];
  assign nxt    = at_end ? cur_q : (dir_q ? (cur_q << 1) : (cur_q >> 1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cur_d   = cur_q;
    trav_d  = trav_q;
    door_d  = door_q;
    arr_d   = 1'b0;
    clr     = 1'b0;
    ack_d   = req_ok;
    err_d   = req_valid && !req_ok;
    unique case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d = S_BUSY;
          arr_d   = 1'b1;
          door_d  = '0;
        end else if (ahead) begin
          state_d = S_TRAV;
          trav_d  = '0;
        end else if (behind) begin
          state_d = S_TRAV;
          dir_d   = ~dir_q;
          trav_d  = '0;
        end
      end
      S_TRAV: begin
        if (tick) begin
          if (trav_q == TRAV_LAST) begin
            trav_d = '0;
            cur_d  = nxt;
            if (|(nxt & pend_q)) begin
              state_d = S_BUSY;
              arr_d   = 1'b1;
              door_d  = '0;
            end
          end else begin
            trav_d = trav_q + 4'd1;
          end
        end
      end
      S_BUSY: begin
        if (hold) begin
          door_d = '0;
        end else if (tick) begin
          if (door_q == DOOR_LAST) begin
            clr    = 1'b1;
            door_d = '0;
            trav_d = '0;
            if (ahead) begin
              state_d = S_TRAV;
            end else if (behind) begin
              state_d = S_TRAV;
              dir_d   = ~dir_q;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            door_d = door_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Clear beats a same-cycle request for this floor.
    pend_d = (pend_q | set_mask) & ~(clr ? cur_q : '0);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b1;
      cur_q   <= ONE;
      pend_q  <= '0;
      trav_q  <= '0;
      door_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      arr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      trav_q  <= trav_d;
      door_q  <= door_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      arr_q   <= arr_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign pending   = pend_q;
  assign cur_floor = cur_q;
  assign state     = state_q;
  assign direction = dir_q;
  assign door_open = (state_q == S_BUSY);
  assign arrive    = arr_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed self-checking bench for elevator_dispatcher.
// Covers travel, SCAN reversal, range errors, door-close race and reset.
module tb_elevator_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'd0;
  logic       door_hold = 1'b0;
  logic       req_ack, req_err, direction, door_open, arrive;
  logic [9:0] pending, cur_floor;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] BUSY = 2'b10;
  localparam logic [1:0] TRAV = 2'b11;

  always #10 clk = ~clk;

  elevator_dispatcher dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .req_valid(req_valid),
    .req_floor(req_floor),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .req_ack  (req_ack),
    .req_err  (req_err),
    .pending  (pending),
    .cur_floor(cur_floor),
    .state    (state),
    .direction(direction),
    .door_open(door_open),
    .arrive   (arrive)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs, then sample 1 time unit later.
  task automatic cyc(input logic tk, input logic v, input logic [3:0] f);
    tick = tk;
    req_valid = v;
    req_floor = f;
    @(posedge clk);
    #1;
    tick = 1'b0;
    req_valid = 1'b0;
    req_floor = 4'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0);
  endtask

  task automatic request(input logic [3:0] f);
    cyc(1'b0, 1'b1, f);
  endtask

  initial begin
    #25;
    chk("rst_state", state, IDLE);
    chk("rst_dir", direction, 1'b1);
    chk("rst_cur", cur_floor, 10'h001);
    chk("rst_pend", pending, 10'h000);
    chk("rst_door", door_open, 1'b0);
    chk("rst_ack", req_ack, 1'b0);
    chk("rst_err", req_err, 1'b0);
    chk("rst_arr", arrive, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Floor 4 from floor 1.
    request(4'd4);
    chk("f4_ack", req_ack, 1'b1);
    chk("f4_pend", pending, 10'h008);
    chk("f4_idle", state, IDLE);
    cyc(1'b0, 1'b0, 4'd0);
    chk("f4_trav", state, TRAV);
    chk("f4_dir", direction, 1'b1);
    chk("f4_ack0", req_ack, 1'b0);
    ticks(2);
    chk("f4_cur3", cur_floor, 10'h004);
    chk("f4_trav2", state, TRAV);
    ticks(1);
    chk("f4_cur4", cur_floor, 10'h008);
    chk("f4_busy", state, BUSY);
    chk("f4_arr", arrive, 1'b1);
    chk("f4_door", door_open, 1'b1);
    cyc(1'b0, 1'b0, 4'd0);
    chk("f4_arr0", arrive, 1'b0);
    ticks(4);
    chk("f4_busy4", state, BUSY);
    ticks(1);
    chk("f4_idle2", state, IDLE);
    chk("f4_pend0", pending, 10'h000);
    chk("f4_door0", door_open, 1'b0);

    // Up to 5, then calls at 2 and 8: serve 8 first, then reverse.
    request(4'd5);
    cyc(1'b0, 1'b0, 4'd0);
    ticks(1);
    chk("s5_cur", cur_floor, 10'h010);
    chk("s5_busy", state, BUSY);
    request(4'd2);
    request(4'd8);
    chk("s5_pend", pending, 10'h092);
    ticks(5);
    chk("s5_trav", state, TRAV);
    chk("s5_dir", direction, 1'b1);
    chk("s5_pend2", pending, 10'h082);
    ticks(2);
    chk("s5_cur7", cur_floor, 10'h040);
    chk("s5_trav7", state, TRAV);
    ticks(1);
    chk("s8_cur", cur_floor, 10'h080);
    chk("s8_busy", state, BUSY);
    chk("s8_arr", arrive, 1'b1);
    ticks(5);
    chk("s8_trav", state, TRAV);
    chk("s8_dir", direction, 1'b0);
    chk("s8_pend", pending, 10'h002);
    ticks(5);
    chk("s3_cur", cur_floor, 10'h004);
    chk("s3_trav", state, TRAV);
    ticks(1);
    chk("s2_cur", cur_floor, 10'h002);
    chk("s2_busy", state, BUSY);
    chk("s2_arr", arrive, 1'b1);
    ticks(5);
    chk("s2_idle", state, IDLE);
    chk("s2_pend", pending, 10'h000);
    chk("s2_dir", direction, 1'b0);

    // Down to 1, idle ticks ignored, then a call at the current floor.
    request(4'd1);
    cyc(1'b0, 1'b0, 4'd0);
    chk("d1_trav", state, TRAV);
    ticks(1);
    chk("d1_cur", cur_floor, 10'h001);
    chk("d1_busy", state, BUSY);
    ticks(5);
    chk("d1_idle", state, IDLE);
    ticks(2);
    chk("idle_tick_cur", cur_floor, 10'h001);
    chk("idle_tick_st", state, IDLE);
    request(4'd1);
    chk("h1_pend", pending, 10'h001);
    cyc(1'b0, 1'b0, 4'd0);
    chk("h1_busy", state, BUSY);
    chk("h1_arr", arrive, 1'b1);
    chk("h1_cur", cur_floor, 10'h001);
    ticks(4);
    chk("h1_door4", door_open, 1'b1);
    ticks(1);
    chk("h1_idle", state, IDLE);
    chk("h1_pend0", pending, 10'h000);

    // Out-of-range requests.
    request(4'd0);
    chk("r0_err", req_err, 1'b1);
    chk("r0_ack", req_ack, 1'b0);
    chk("r0_pend", pending, 10'h000);
    request(4'd11);
    chk("r11_err", req_err, 1'b1);
    chk("r11_pend", pending, 10'h000);
    request(4'd15);
    chk("r15_err", req_err, 1'b1);
    cyc(1'b0, 1'b0, 4'd0);
    chk("r_err0", req_err, 1'b0);
    chk("r_idle", state, IDLE);
    request(4'd10);
    chk("r10_err", req_err, 1'b0);
    chk("r10_ack", req_ack, 1'b1);
    chk("r10_pend", pending, 10'h200);
    cyc(1'b0, 1'b0, 4'd0);
    chk("r10_trav", state, TRAV);
    chk("r10_dir", direction, 1'b1);
    ticks(8);
    chk("r10_cur9", cur_floor, 10'h100);
    ticks(1);
    chk("r10_cur", cur_floor, 10'h200);
    chk("r10_busy", state, BUSY);
    ticks(5);
    chk("r10_idle", state, IDLE);

    // Request the current floor mid-dwell and in the door-close cycle.
    request(4'd10);
    cyc(1'b0, 1'b0, 4'd0);
    chk("dc_busy", state, BUSY);
    ticks(2);
    request(4'd10);
    chk("dc_ack", req_ack, 1'b1);
    chk("dc_pend", pending, 10'h200);
    ticks(2);
    cyc(1'b1, 1'b1, 4'd10);
    chk("dc_ack2", req_ack, 1'b1);
    chk("dc_idle", state, IDLE);
    chk("dc_pend0", pending, 10'h000);
    cyc(1'b0, 1'b0, 4'd0);
    chk("dc_idle2", state, IDLE);
    chk("dc_arr0", arrive, 1'b0);

    // Reset while travelling down toward floor 5.
    request(4'd5);
    cyc(1'b0, 1'b0, 4'd0);
    chk("rt_dir", direction, 1'b0);
    ticks(2);
    chk("rt_cur", cur_floor, 10'h080);
    chk("rt_trav", state, TRAV);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", state, IDLE);
    chk("ar_dir", direction, 1'b1);
    chk("ar_cur", cur_floor, 10'h001);
    chk("ar_pend", pending, 10'h000);
    chk("ar_door", door_open, 1'b0);
    chk("ar_arr", arrive, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_idle", state, IDLE);

`ifdef ELEV_DOOR_HOLD_EN
    request(4'd1);
    cyc(1'b0, 1'b0, 4'd0);
    chk("dh_busy", state, BUSY);
    door_hold = 1'b1;
    ticks(3);
    chk("dh_held", state, BUSY);
    door_hold = 1'b0;
    ticks(4);
    chk("dh_busy7", state, BUSY);
    ticks(1);
    chk("dh_idle", state, IDLE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Collective-control scheduler for the 10-floor elevator. Latches floor requests into a pending register and picks the travel direction using SCAN ordering: keep going while calls remain ahead, reverse only when none do. Steps the car position on 1-second enable ticks and sequences the door-open (BUSY) dwell. Sits between the switch/key request logic and the HEX/LED display decoders, and owns the IDLE/BUSY/TRAVELING state and the direction bit.

## Interface
- NUM_FLOORS, 10, number of floors; floor numbers run 1..NUM_FLOORS (max 15)
- DOOR_TICKS, 5, ticks the door stays open in BUSY
- TRAVEL_TICKS, 1, ticks per single-floor move
- CLOCK_50  in  1  system clock; all state registers on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle enable pulse, once per second (not a clock)
- req_valid  in  1  request strobe, one cycle
- req_floor  in  4  requested floor, binary 1..NUM_FLOORS
- req_ack  out  1  one-cycle pulse: request accepted
- req_err  out  1  one-cycle pulse: request out of range (0 or >NUM_FLOORS)
- pending  out  NUM_FLOORS  outstanding calls; bit i = floor i+1 (drives LEDR)
- cur_floor  out  NUM_FLOORS  one-hot car position; bit 0 = floor 1
- state  out  2  01 IDLE, 10 BUSY, 11 TRAVELING (00 never driven)
- direction  out  1  1 UP, 0 DOWN
- door_open  out  1  high exactly while state==BUSY
- arrive  out  1  one-cycle pulse on entry to BUSY

## Operation
- Reset values: state=IDLE, direction=UP, cur_floor=1 (one-hot bit 0), pending=0, door_open=0, req_ack=0, req_err=0, arrive=0, tick counters=0.
- Request latch: valid req_floor sets pending[req_floor-1] and pulses req_ack. Out-of-range pulses req_err and changes nothing. A duplicate request is acked and has no further effect.
- ahead/behind: any pending bit above or below cur_floor relative to direction. here: the pending bit at cur_floor.
- IDLE:
  - here → BUSY.
  - else ahead → TRAVELING, direction unchanged.
  - else behind → TRAVELING, direction inverted.
  - else stay in IDLE.
  - With calls both above and below, the retained direction wins.
- TRAVELING:
  - travel counter counts ticks; on the TRAVEL_TICKS-th tick, cur_floor shifts one position in direction and the counter clears.
  - If the new position has a pending bit → BUSY with arrive pulse; otherwise stay in TRAVELING.
- BUSY:
  - door counter counts ticks; the DOOR_TICKS-th tick is door close.
  - At door close: clear pending[cur_floor], then evaluate ahead, then behind (inverting direction), else IDLE. The choice uses pending after the clear.
- Boundaries:
  - cur_floor never shifts past floor 1 or NUM_FLOORS. A move is only ever taken toward a pending bit.
  - At either end, "ahead" is always false.
- Simultaneous events:
  - A request for cur_floor in the door-close cycle: the clear wins and the door does not reopen.
  - A request for cur_floor during BUSY before close: acked, and the bit is cleared at close.
  - A request for cur_floor during TRAVELING: treated as a normal call at that floor.
- Reset mid-operation: everything returns to reset values immediately. Pending calls are lost.

## Timing
- req_ack/req_err: registered, asserted the cycle after req_valid. pending updates on that same edge.
- IDLE→TRAVELING or IDLE→BUSY: one CLOCK_50 cycle after pending becomes nonzero.
- Floor step: TRAVEL_TICKS ticks after entering TRAVELING. The BUSY decision at the new floor registers on the same edge as the shift.
- Door dwell: exactly DOOR_TICKS ticks. A tick in the BUSY-entry cycle is not counted.
- tick pulses arriving outside TRAVELING/BUSY are ignored.

## Configuration
- ELEV_DOOR_HOLD_EN defined:
  - adds input door_hold (1 bit).
  - While door_hold=1 in BUSY, the door counter holds at 0; counting restarts from 0 on release.
- Not defined: no door_hold port; dwell is always DOOR_TICKS.

## Test plan
- Reset, then request floor 4 → req_ack next cycle, pending=0x008, TRAVELING UP. 3 ticks later cur_floor=0x008, arrive, BUSY. 5 ticks later pending=0, IDLE.
- At floor 5 going UP, pending floors 2 and 8 → visits 8 first, then reverses: direction=0, arrives at 2.
- Request floor 1 while idle at floor 1 → BUSY next cycle (no travel), door_open for 5 ticks, pending cleared.
- req_floor=0 and req_floor=11 → req_err each, pending unchanged, state stays IDLE.
- Request for the current floor in the exact door-close cycle → pending bit ends cleared, state→IDLE, no second BUSY.
- rst_n low during TRAVELING between floors → all outputs at reset values asynchronously. With ELEV_DOOR_HOLD_EN, door_hold high for 3 ticks extends BUSY to 8 ticks.
